// File: rtl/f_pcgen_pkg.sv
// Shared constants and BTB entry layout for the fetch PC generator and the
// execute-side BTB entry packer.
package f_pcgen_pkg;

  localparam int PC_W_DEF     = 13;
  localparam int IDX_W_DEF    = 11;
  localparam int RESET_PC_DEF = 0;

  // Default-geometry field positions of a BTB entry {valid, tag, target}.
  localparam int TAG_W_DEF     = PC_W_DEF - IDX_W_DEF;
  localparam int VALID_POS_DEF = TAG_W_DEF + PC_W_DEF;
  localparam int TAG_LSB_DEF   = PC_W_DEF;
  localparam int TGT_LSB_DEF   = 0;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } pcgen_state_t;

  // Tag width: the PC bits above the BTB index.
  function automatic int btb_tag_w(input int pc_w, input int idx_w);
    return pc_w - idx_w;
  endfunction

  // Position of the valid bit; it sits directly above tag and target.
  function automatic int btb_valid_pos(input int pc_w, input int idx_w);
    return (pc_w - idx_w) + pc_w;
  endfunction

  // Total entry width: valid + tag + target.
  function automatic int btb_entry_w(input int pc_w, input int idx_w);
    return 1 + (pc_w - idx_w) + pc_w;
  endfunction

endpackage

// File: rtl/f_btb.sv
// Branch target buffer: direct-mapped register array with a clear port used
// by the init sweep, one execute write port, and a combinational lookup that
// forwards a same-cycle write to the reader.
module f_btb
  import f_pcgen_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic                                 clk,
  input  logic                                 clr_en,
  input  logic [IDX_W-1:0]                     clr_addr,
  input  logic                                 wr_en,
  input  logic [IDX_W-1:0]                     wr_addr,
  input  logic [btb_entry_w(PC_W, IDX_W)-1:0]  wr_data,
  input  logic [PC_W-1:0]                      rd_pc,
  output logic                                 hit,
  output logic [PC_W-1:0]                      target
);

  localparam int TAG_W     = btb_tag_w(PC_W, IDX_W);
  localparam int ENT_W     = btb_entry_w(PC_W, IDX_W);
  localparam int VALID_POS = btb_valid_pos(PC_W, IDX_W);
  localparam int DEPTH     = 2 ** IDX_W;

  // Storage is deliberately not reset; the init sweep clears it.
  logic [ENT_W-1:0] mem [DEPTH];
  logic [ENT_W-1:0] entry;
  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;

  // Clear has priority; the top never asserts both in the same cycle.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[clr_addr] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Lookup at the current PC, forwarding a write to the same index.
  always_comb begin
    rd_idx = rd_pc[IDX_W-1:0];
    rd_tag = rd_pc[PC_W-1:IDX_W];
    entry  = mem[rd_idx];
    if (wr_en && (wr_addr == rd_idx)) begin
      entry = wr_data;
    end
    hit    = entry[VALID_POS] && (entry[VALID_POS-1 -: TAG_W] == rd_tag);
    target = entry[PC_W-1:0];
  end

endmodule

// File: rtl/f_pcgen.sv
// Fetch-stage PC generator: sweeps the BTB clear after reset, then fetches
// sequentially or along BTB-predicted targets, redirecting on execute
// mispredictions with a one-cycle flush pulse.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_INIT | clearing one BTB entry per cycle, PC parked at RESET_PC
// ST_RUN  | normal fetch; left only through rst_n
module f_pcgen
  import f_pcgen_pkg::*;
#(
  parameter int PC_W     = PC_W_DEF,
  parameter int IDX_W    = IDX_W_DEF,
  parameter int RESET_PC = RESET_PC_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 stall,
  input  logic                                 fail_predict,
  input  logic [PC_W-1:0]                      correct_pc,
  input  logic [btb_entry_w(PC_W, IDX_W)-1:0]  w_data,
  input  logic [IDX_W-1:0]                     w_addr,
  input  logic                                 wen,
  output logic [PC_W-1:0]                      pc,
  output logic [PC_W-1:0]                      pc_predicted,
  output logic                                 fetch_valid,
  output logic                                 flush,
  output logic                                 init_busy
);

  localparam logic [PC_W-1:0]  RST_PC   = PC_W'(RESET_PC);
  localparam logic [IDX_W-1:0] CNT_LAST = '1;

  pcgen_state_t     state, state_nxt;
  logic [IDX_W-1:0] init_cnt;
  logic [PC_W-1:0]  pc_nxt;
  logic             flush_nxt;
  logic             run;
  logic             btb_hit;
  logic [PC_W-1:0]  btb_target;

  f_btb #(
    .PC_W  (PC_W),
    .IDX_W (IDX_W)
  ) u_btb (
    .clk      (clk),
    .clr_en   (!run),
    .clr_addr (init_cnt),
    .wr_en    (run && wen),
    .wr_addr  (w_addr),
    .wr_data  (w_data),
    .rd_pc    (pc),
    .hit      (btb_hit),
    .target   (btb_target)
  );

  // State, sweep counter, PC and flush registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      pc       <= RST_PC;
      flush    <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      flush    <= flush_nxt;
      if (state == ST_INIT) begin
        init_cnt <= init_cnt + 1'b1;
      end
    end
  end

  // Next state, next PC and outputs; a redirect beats stall, stall beats prediction.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    flush_nxt    = 1'b0;
    run          = 1'b0;
    init_busy    = 1'b0;
    fetch_valid  = 1'b0;
    pc_predicted = btb_hit ? btb_target : (pc + PC_W'(1));
    case (state)
      ST_INIT: begin
        init_busy = 1'b1;
        pc_nxt    = RST_PC;
        if (init_cnt == CNT_LAST) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        run         = 1'b1;
        fetch_valid = !flush;
        if (fail_predict) begin
          pc_nxt    = correct_pc;
          flush_nxt = 1'b1;
        end else if (!stall) begin
          pc_nxt = pc_predicted;
        end
      end
      default: begin
        state_nxt = ST_INIT;
      end
    endcase
  end

endmodule

// File: doc/f_pcgen.md
Name: f_pcgen

Overview:
Fetch-stage PC generator with an integrated branch target buffer (BTB). It holds the architectural fetch PC (13-bit word address) and predicts the next PC from the BTB. It receives BTB updates and misprediction redirects from the execute-stage PC calculator. For every fetched instruction it sends the PC and the predicted next PC downstream; execute later compares that prediction against the resolved next PC.

Parameters:
PC_W, 13, PC width in words (byte address bits [PC_W+1:2])
IDX_W, 11, BTB index width; BTB depth = 2**IDX_W
RESET_PC, 0, fetch PC after reset / init

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
stall  in  1  hold PC (downstream hazard)
fail_predict  in  1  execute misprediction, redirect required
correct_pc  in  PC_W  resolved next PC from execute
w_data  in  1+(PC_W-IDX_W)+PC_W  BTB entry {valid, tag, target}
w_addr  in  IDX_W  BTB write index
wen  in  1  BTB write enable
pc  out  PC_W  current fetch PC to instruction memory
pc_predicted  out  PC_W  predicted next PC, travels with instruction
fetch_valid  out  1  pc/pc_predicted describe a real fetch
flush  out  1  squash younger instructions in F/D this cycle
init_busy  out  1  BTB clear sweep in progress

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: pc=RESET_PC, fetch_valid=0, flush=0, init_busy=1, FSM=INIT, init counter=0.
- BTB entry format, TAG_W=PC_W-IDX_W: bit[TAG_W+PC_W]=valid, next TAG_W bits=tag (pc[PC_W-1:IDX_W]), low PC_W bits=target.
- BTB storage: register array, not reset directly; cleared by the INIT sweep.
- FSM INIT:
  - Each cycle write entry[init_cnt]=0, then init_cnt+1.
  - When init_cnt==2**IDX_W-1 is written, go to RUN the next cycle.
  - Duration is exactly 2**IDX_W cycles.
  - pc is held at RESET_PC; fetch_valid=0; flush=0; wen, stall and fail_predict are ignored.
- FSM RUN:
  - init_busy=0; fetch_valid=1 except in the flush cycle.
  - RUN is never left except through rst_n.
- Lookup is combinational on the current pc: entry=btb[pc[IDX_W-1:0]].
  - Bypass: if wen and w_addr==pc[IDX_W-1:0] in the same cycle, use w_data as the entry.
  - hit = entry.valid & (entry.tag == pc[PC_W-1:IDX_W]).
- pc_predicted = hit ? entry.target : pc+1, modulo 2**PC_W (1FFF+1 -> 0000). It is valid in the same cycle as pc.
- Next-PC priority in RUN, highest first:
  1. fail_predict: pc<=correct_pc, and flush=1 registered for one cycle. In that cycle fetch_valid=0, because the fetch at the stale PC is squashed. stall is ignored.
  2. stall: pc held. pc_predicted recomputes from the same pc (may change if a bypassed write hits).
  3. Otherwise pc<=pc_predicted.
- BTB write: on clk rising edge in RUN with wen=1, btb[w_addr]<=w_data. The write completes in the same cycle as any redirect. Every entry written by execute has valid=1, so a hit always predicts taken.
- flush is a registered one-cycle pulse. Back-to-back fail_predict gives flush high on consecutive cycles, and the last correct_pc wins.
- rst_n asserted mid-RUN: FSM returns to INIT asynchronously and the BTB is re-swept. In-flight wen is lost.

Decomposition:
- Shared package/define header: PC_W, IDX_W, TAG_W, BTB entry field offsets (valid bit position, tag slice, target slice), RESET_PC. The execute-side packer uses the same constants.
- One natural sub-module, f_btb: storage array, init sweep port, write port, combinational read with bypass, hit/target outputs.
- The FSM and PC register stay in f_pcgen.

Test Plan:
- Reset, then run IDX_W=4: init_busy=1 for exactly 16 cycles with pc=0000 and fetch_valid=0. The first RUN cycle shows pc=0000, pc_predicted=0001.
- Sequential fetch from 0000: pc steps 0000,0001,0002,… with pc_predicted=pc+1. Forcing pc=1FFF yields pc_predicted=0000.
- Write w_addr=0005, w_data={1,tag 0,0100} one cycle before pc reaches 0005: pc_predicted=0100 and the next pc is 0100. Same write with tag=1 (mismatch): pc_predicted=0006.
- wen with w_addr equal to the current pc index in the same cycle: bypass gives pc_predicted=w_data target in that cycle.
- fail_predict=1 with correct_pc=0123 while stall=1: next cycle pc=0123, flush=1, fetch_valid=0. The following cycle flush=0 and fetch_valid=1.
- rst_n low mid-RUN after BTB writes: init_busy reasserts asynchronously. After the sweep, the previously written index misses (pc_predicted=pc+1).
